// File: rtl/pdm_pcm_packer.sv
// PDM PCM packer: tags 16-bit PCM samples with their channel index, sign-extends
// or pairs them into 32-bit words, and buffers the words in a small FIFO that
// drops new words (sticky overflow) when full, since the PDM path cannot stall.
module pdm_pcm_packer #(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                          clk_i,
    input  logic                          rstn_i,
    input  logic                          cfg_en_i,
    input  logic [1:0]                    cfg_ch_mode_i,
    input  logic                          cfg_pack_i,
    input  logic                          clr_ovf_i,
    input  logic [15:0]                   pcm_data_i,
    input  logic                          pcm_valid_i,
    output logic [31:0]                   data_o,
    output logic [1:0]                    ch_o,
    output logic                          data_valid_o,
    input  logic                          data_ready_i,
    output logic [$clog2(FIFO_DEPTH):0]   fill_o,
    output logic                          ovf_o
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef struct packed {
        logic [1:0]  ch;
        logic [31:0] data;
    } entry_t;

    typedef enum logic {ST_LOW, ST_HIGH} half_state_e;

    half_state_e    state_q, state_d;
    logic [15:0]    half_q, half_d;
    logic [1:0]     tag_q, tag_d;
    logic [1:0]     ch_q, ch_d;
    entry_t         mem_q [FIFO_DEPTH];
    entry_t         mem_d [FIFO_DEPTH];
    logic [AW-1:0]  rd_q, rd_d;
    logic [AW-1:0]  wr_q, wr_d;
    logic [CW-1:0]  cnt_d;
    logic           ovf_d;
    logic [1:0]     ch_max;
    logic           push, pop, push_ok;
    entry_t         word;
    entry_t         head_d;

    // Highest channel index for the configured channel count
    always_comb begin
        ch_max = 2'd0;
        case (cfg_ch_mode_i)
            2'b00:   ch_max = 2'd0;
            2'b01:   ch_max = 2'd1;
            2'b10:   ch_max = 2'd1;
            default: ch_max = 2'd3;
        endcase
    end

    // Half-word FSM state register
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) state_q <= ST_LOW;
        else         state_q <= state_d;
    end

    // Next-state: channel counter, half FSM, FIFO pointers, overflow
    always_comb begin
        state_d = state_q;
        half_d  = half_q;
        tag_d   = tag_q;
        ch_d    = ch_q;
        mem_d   = mem_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        cnt_d   = fill_o;
        ovf_d   = ovf_o;
        push    = 1'b0;
        pop     = 1'b0;
        push_ok = 1'b0;
        word    = '0;

        if (clr_ovf_i) ovf_d = 1'b0;

        if (!cfg_en_i) begin
            state_d = ST_LOW;
            half_d  = '0;
            tag_d   = '0;
            ch_d    = '0;
            rd_d    = '0;
            wr_d    = '0;
            cnt_d   = '0;
        end else begin
            pop = (fill_o != '0) && data_ready_i;
            if (pcm_valid_i) begin
                // Wrap also catches an out-of-range count after an illegal mode change
                ch_d = (ch_q >= ch_max) ? 2'd0 : ch_q + 2'd1;
                if (!cfg_pack_i) begin
                    push      = 1'b1;
                    word.ch   = ch_q;
                    word.data = {{16{pcm_data_i[15]}}, pcm_data_i};
                end else if (state_q == ST_LOW) begin
                    half_d  = pcm_data_i;
                    tag_d   = ch_q;
                    state_d = ST_HIGH;
                end else begin
                    push      = 1'b1;
                    word.ch   = tag_q;
                    word.data = {pcm_data_i, half_q};
                    state_d   = ST_LOW;
                end
            end
            if (pop) rd_d = rd_q + AW'(1);
            if (push) begin
                if ((fill_o != CW'(FIFO_DEPTH)) || pop) begin
                    push_ok     = 1'b1;
                    mem_d[wr_q] = word;
                    wr_d        = wr_q + AW'(1);
                end else begin
                    ovf_d = 1'b1;
                end
            end
            cnt_d = fill_o + CW'(push_ok) - CW'(pop);
        end
        head_d = mem_d[rd_d];
    end

    // Datapath and registered outputs; head word forced to zero when empty
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            half_q       <= '0;
            tag_q        <= '0;
            ch_q         <= '0;
            rd_q         <= '0;
            wr_q         <= '0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= '0;
            fill_o       <= '0;
            ovf_o        <= 1'b0;
            data_valid_o <= 1'b0;
            data_o       <= '0;
            ch_o         <= '0;
        end else begin
            half_q       <= half_d;
            tag_q        <= tag_d;
            ch_q         <= ch_d;
            rd_q         <= rd_d;
            wr_q         <= wr_d;
            mem_q        <= mem_d;
            fill_o       <= cnt_d;
            ovf_o        <= ovf_d;
            data_valid_o <= (cnt_d != '0);
            data_o       <= (cnt_d != '0) ? head_d.data : 32'd0;
            ch_o         <= (cnt_d != '0) ? head_d.ch   : 2'd0;
        end
    end

endmodule

// File: tb/tb_pdm_pcm_packer.sv
// Self-checking bench for pdm_pcm_packer: directed scenarios plus randomized
// traffic compared against a sample-stream reference model.
module tb_pdm_pcm_packer;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned FW    = 3;

    logic          clk_i = 1'b0;
    logic          rstn_i;
    logic          cfg_en_i;
    logic [1:0]    cfg_ch_mode_i;
    logic          cfg_pack_i;
    logic          clr_ovf_i;
    logic [15:0]   pcm_data_i;
    logic          pcm_valid_i;
    logic [31:0]   data_o;
    logic [1:0]    ch_o;
    logic          data_valid_o;
    logic          data_ready_i;
    logic [FW-1:0] fill_o;
    logic          ovf_o;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: queue of {ch, word}, overflow flag, sample index, pending half
    logic [33:0] mq[$];
    bit          m_ovf;
    int          m_sidx;
    bit          m_hv;
    logic [15:0] m_hd;
    logic [1:0]  m_hc;

    always #5 clk_i = ~clk_i;

    pdm_pcm_packer #(.FIFO_DEPTH(DEPTH)) dut (
        .clk_i         (clk_i),
        .rstn_i        (rstn_i),
        .cfg_en_i      (cfg_en_i),
        .cfg_ch_mode_i (cfg_ch_mode_i),
        .cfg_pack_i    (cfg_pack_i),
        .clr_ovf_i     (clr_ovf_i),
        .pcm_data_i    (pcm_data_i),
        .pcm_valid_i   (pcm_valid_i),
        .data_o        (data_o),
        .ch_o          (ch_o),
        .data_valid_o  (data_valid_o),
        .data_ready_i  (data_ready_i),
        .fill_o        (fill_o),
        .ovf_o         (ovf_o)
    );

    function automatic int nch(input logic [1:0] m);
        case (m)
            2'b00:   return 1;
            2'b11:   return 4;
            default: return 2;
        endcase
    endfunction

    function automatic logic [38:0] model_obs();
        logic [33:0] h;
        h = (mq.size() != 0) ? mq[0] : 34'd0;
        return {mq.size() != 0, FW'(mq.size()), m_ovf, h};
    endfunction

    task automatic model_reset();
        mq.delete();
        m_ovf  = 0;
        m_sidx = 0;
        m_hv   = 0;
        m_hd   = '0;
        m_hc   = '0;
    endtask

    // Apply one cycle of inputs, advance the model at the edge, settle #1 after
    task automatic step(input bit en, input bit vld, input logic [15:0] d,
                        input bit rdy, input bit clr);
        bit          pop, push, full;
        logic [33:0] w;
        logic [1:0]  ch;
        cfg_en_i     = en;
        pcm_valid_i  = vld;
        pcm_data_i   = d;
        data_ready_i = rdy;
        clr_ovf_i    = clr;
        @(posedge clk_i);
        push = 0;
        w    = '0;
        if (clr) m_ovf = 0;
        if (!en) begin
            mq.delete();
            m_sidx = 0;
            m_hv   = 0;
        end else begin
            pop  = (mq.size() != 0) && rdy;
            full = (mq.size() == DEPTH);
            if (vld) begin
                ch     = 2'(m_sidx % nch(cfg_ch_mode_i));
                m_sidx = (m_sidx + 1) % nch(cfg_ch_mode_i);
                if (!cfg_pack_i) begin
                    push = 1;
                    w    = {ch, {16{d[15]}}, d};
                end else if (!m_hv) begin
                    m_hv = 1;
                    m_hd = d;
                    m_hc = ch;
                end else begin
                    m_hv = 0;
                    push = 1;
                    w    = {m_hc, d, m_hd};
                end
            end
            if (pop) void'(mq.pop_front());
            if (push) begin
                if (full && !pop) m_ovf = 1;
                else mq.push_back(w);
            end
        end
        #1;
        pcm_valid_i = 1'b0;
        clr_ovf_i   = 1'b0;
    endtask

    task automatic configure(input logic [1:0] mode, input bit pack);
        cfg_ch_mode_i = mode;
        cfg_pack_i    = pack;
        step(0, 0, 16'h0, 0, 0);
    endtask

    task automatic test_reset();
        n_cmp++; if (data_o !== 32'd0) begin n_err++; $display("FAIL reset_data got=%h exp=0", data_o); end
        n_cmp++; if (ch_o !== 2'd0) begin n_err++; $display("FAIL reset_ch got=%0d exp=0", ch_o); end
        n_cmp++; if (data_valid_o !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%b exp=0", data_valid_o); end
        n_cmp++; if (fill_o !== '0) begin n_err++; $display("FAIL reset_fill got=%0d exp=0", fill_o); end
        n_cmp++; if (ovf_o !== 1'b0) begin n_err++; $display("FAIL reset_ovf got=%b exp=0", ovf_o); end
    endtask

    task automatic test_unpacked();
        logic [15:0] s [4];
        logic [31:0] e [4];
        s[0] = 16'h8001; s[1] = 16'h0002; s[2] = 16'h7FFF; s[3] = 16'h0004;
        e[0] = 32'hFFFF8001; e[1] = 32'h00000002; e[2] = 32'h00007FFF; e[3] = 32'h00000004;
        configure(2'b11, 0);
        for (int i = 0; i < 4; i++) begin
            step(1, 1, s[i], 1, 0);
            n_cmp++;
            if ({data_valid_o, ch_o, data_o} !== {1'b1, 2'(i), e[i]})
                begin n_err++; $display("FAIL unpacked_%0d got=%b/%0d/%h exp=1/%0d/%h", i, data_valid_o, ch_o, data_o, i, e[i]); end
        end
        step(1, 0, 16'h0, 1, 0);
        n_cmp++; if (data_valid_o !== 1'b0) begin n_err++; $display("FAIL unpacked_drain got=%b exp=0", data_valid_o); end
    endtask

    task automatic test_packed();
        configure(2'b01, 1);
        step(1, 1, 16'h1111, 0, 0);
        n_cmp++; if (data_valid_o !== 1'b0) begin n_err++; $display("FAIL packed_first got=%b exp=0", data_valid_o); end
        step(1, 1, 16'h2222, 0, 0);
        n_cmp++;
        if ({data_valid_o, ch_o, data_o} !== {1'b1, 2'd0, 32'h22221111})
            begin n_err++; $display("FAIL packed_w0 got=%b/%0d/%h exp=1/0/22221111", data_valid_o, ch_o, data_o); end
        step(1, 1, 16'h3333, 0, 0);
        step(1, 1, 16'h4444, 0, 0);
        n_cmp++; if (fill_o !== 3'd2) begin n_err++; $display("FAIL packed_fill got=%0d exp=2", fill_o); end
        step(1, 0, 16'h0, 1, 0);
        n_cmp++;
        if ({data_valid_o, ch_o, data_o} !== {1'b1, 2'd0, 32'h44443333})
            begin n_err++; $display("FAIL packed_w1 got=%b/%0d/%h exp=1/0/44443333", data_valid_o, ch_o, data_o); end
        step(1, 0, 16'h0, 1, 0);
    endtask

    task automatic test_overflow();
        logic [15:0] s [5];
        configure(2'b00, 0);
        for (int i = 0; i < 5; i++) begin
            s[i] = 16'($urandom);
            step(1, 1, s[i], 0, 0);
        end
        n_cmp++; if (fill_o !== 3'd4) begin n_err++; $display("FAIL ovf_fill got=%0d exp=4", fill_o); end
        n_cmp++; if (ovf_o !== 1'b1) begin n_err++; $display("FAIL ovf_set got=%b exp=1", ovf_o); end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (data_o !== {{16{s[i][15]}}, s[i]})
                begin n_err++; $display("FAIL ovf_drain_%0d got=%h exp=%h", i, data_o, {{16{s[i][15]}}, s[i]}); end
            step(1, 0, 16'h0, 1, 0);
        end
        n_cmp++; if ({data_valid_o, fill_o, ovf_o} !== {1'b0, 3'd0, 1'b1})
            begin n_err++; $display("FAIL ovf_empty got=%b/%0d/%b exp=0/0/1", data_valid_o, fill_o, ovf_o); end
        step(1, 0, 16'h0, 0, 1);
        n_cmp++; if (ovf_o !== 1'b0) begin n_err++; $display("FAIL ovf_clear got=%b exp=0", ovf_o); end
    endtask

    task automatic test_full_push_pop();
        logic [15:0] s [5];
        configure(2'b00, 0);
        for (int i = 0; i < 5; i++) s[i] = 16'($urandom);
        for (int i = 0; i < 4; i++) step(1, 1, s[i], 0, 0);
        step(1, 1, s[4], 1, 0);
        n_cmp++; if ({fill_o, ovf_o} !== {3'd4, 1'b0})
            begin n_err++; $display("FAIL fullpp_state got=%0d/%b exp=4/0", fill_o, ovf_o); end
        for (int i = 1; i < 5; i++) begin
            n_cmp++;
            if (data_o !== {{16{s[i][15]}}, s[i]})
                begin n_err++; $display("FAIL fullpp_drain_%0d got=%h exp=%h", i, data_o, {{16{s[i][15]}}, s[i]}); end
            step(1, 0, 16'h0, 1, 0);
        end
    endtask

    task automatic test_flush();
        configure(2'b01, 1);
        step(1, 1, 16'h5555, 0, 0);
        step(0, 0, 16'h0, 0, 0);
        n_cmp++; if ({data_valid_o, fill_o} !== {1'b0, 3'd0})
            begin n_err++; $display("FAIL flush_empty got=%b/%0d exp=0/0", data_valid_o, fill_o); end
        step(1, 1, 16'hAAAA, 0, 0);
        n_cmp++; if (data_valid_o !== 1'b0) begin n_err++; $display("FAIL flush_half got=%b exp=0", data_valid_o); end
        step(1, 1, 16'hBBBB, 0, 0);
        n_cmp++;
        if ({fill_o, ch_o, data_o} !== {3'd1, 2'd0, 32'hBBBBAAAA})
            begin n_err++; $display("FAIL flush_word got=%0d/%0d/%h exp=1/0/bbbbaaaa", fill_o, ch_o, data_o); end
    endtask

    task automatic test_random();
        logic [38:0] got;
        for (int c = 0; c < 4; c++) begin
            configure(2'(c == 0 ? 0 : c == 1 ? 3 : c == 2 ? 2 : 3), c >= 2);
            for (int i = 0; i < 300; i++) begin
                step($urandom_range(0, 19) != 0, $urandom_range(0, 2) != 0, 16'($urandom),
                     $urandom_range(0, 2) == 0, $urandom_range(0, 29) == 0);
                got = {data_valid_o, fill_o, ovf_o, ch_o, data_o};
                n_cmp++;
                if (got !== model_obs())
                    begin n_err++; $display("FAIL random_c%0d_i%0d got=%h exp=%h", c, i, got, model_obs()); end
            end
        end
    endtask

    task automatic test_async_reset();
        configure(2'b11, 0);
        for (int i = 0; i < 5; i++) step(1, 1, 16'($urandom), 0, 0);
        step(1, 0, 16'h0, 1, 0);
        n_cmp++; if ({fill_o, ovf_o} !== {3'd3, 1'b1})
            begin n_err++; $display("FAIL arst_pre got=%0d/%b exp=3/1", fill_o, ovf_o); end
        data_ready_i = 1'b0;
        #2 rstn_i = 1'b0;
        #1;
        n_cmp++;
        if ({data_o, ch_o, data_valid_o, fill_o, ovf_o} !== '0)
            begin n_err++; $display("FAIL arst_now got=%h/%0d/%b/%0d/%b exp=all 0", data_o, ch_o, data_valid_o, fill_o, ovf_o); end
        #1 rstn_i = 1'b1;
        model_reset();
        step(1, 0, 16'h0, 0, 0);
        n_cmp++;
        if ({data_o, ch_o, data_valid_o, fill_o, ovf_o} !== '0)
            begin n_err++; $display("FAIL arst_after got=%h/%0d/%b/%0d/%b exp=all 0", data_o, ch_o, data_valid_o, fill_o, ovf_o); end
    endtask

    initial begin
        rstn_i        = 1'b0;
        cfg_en_i      = 1'b0;
        cfg_ch_mode_i = 2'b00;
        cfg_pack_i    = 1'b0;
        clr_ovf_i     = 1'b0;
        pcm_data_i    = '0;
        pcm_valid_i   = 1'b0;
        data_ready_i  = 1'b0;
        model_reset();
        #3;
        test_reset();
        @(negedge clk_i);
        rstn_i = 1'b1;
        test_unpacked();
        test_packed();
        test_overflow();
        test_full_push_pop();
        test_flush();
        test_random();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
